// File: rtl/mem_ctrl_sequencer_pkg.sv
// Shared definitions for the memory-instruction control sequencer:
// state codes, default opcode encodings and ALU operation codes.
package cpu_ctrl_defs;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_DONE = 4'd9,
    S_ERR  = 4'd10
  } state_t;

  localparam logic [4:0] OPC_LD     = 5'b00000;
  localparam logic [4:0] OPC_LDI    = 5'b00001;
  localparam logic [4:0] OPC_ST     = 5'b00010;
  localparam logic [4:0] ALU_OP_ADD = 5'b00011;

endpackage

// File: rtl/mem_ctrl_sequencer_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes: counts cycles without ready and
// flags a timeout on the TIMEOUT-th consecutive not-ready cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic first_cycle,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !ready) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // The count only advances on not-ready cycles, so zero means first cycle.
  assign first_cycle = (count_reg == '0);
  assign expired     = enable && !ready && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_ctrl_sequencer.sv
// Control sequencer for ld/ldi/st: fetch, decode, effective-address add and
// memory access, with a ready handshake and timeout on every memory wait.
module mem_ctrl_sequencer
  import cpu_ctrl_defs::*;
#(
  parameter int                    OPCODE_W = 5,
  parameter int                    ALU_OP_W = 5,
  parameter logic [OPCODE_W-1:0]   OP_LD    = OPCODE_W'(OPC_LD),
  parameter logic [OPCODE_W-1:0]   OP_LDI   = OPCODE_W'(OPC_LDI),
  parameter logic [OPCODE_W-1:0]   OP_ST    = OPCODE_W'(OPC_ST),
  parameter logic [ALU_OP_W-1:0]   ALU_ADD  = ALU_OP_W'(ALU_OP_ADD),
  parameter int                    TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic                PC_select,
  output logic                Z_LO_select,
  output logic                MDR_select,
  output logic                c_select,
  output logic                PC_enable,
  output logic                PC_increment_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                read,
  output logic                write,
  output logic                Gra,
  output logic                Grb,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic [ALU_OP_W-1:0] alu_instruction,
  output logic                busy,
  output logic                done,
  output logic                mem_error,
  output logic [3:0]          state
);

  state_t              state_reg;
  logic [OPCODE_W-1:0] opcode_reg;
  logic                is_ld, is_ldi, is_st, legal_op;
  logic                wait_state, first_cycle, expired;

  assign is_ld    = (opcode_reg == OP_LD);
  assign is_ldi   = (opcode_reg == OP_LDI);
  assign is_st    = (opcode_reg == OP_ST);
  assign legal_op = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) || (ir_opcode == OP_ST);

  // Wait states are never back-to-back, so leaving one is enough to clear.
  assign wait_state = (state_reg == S_T1) ||
                      (state_reg == S_T6 && is_ld) ||
                      (state_reg == S_T7 && is_st);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (!wait_state),
    .enable      (wait_state),
    .ready       (mem_ready),
    .first_cycle (first_cycle),
    .expired     (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      opcode_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_reg <= S_T0;
        S_T0:   state_reg <= S_T1;
        S_T1: begin
          if (mem_ready)    state_reg <= S_T2;
          else if (expired) state_reg <= S_ERR;
        end
        S_T2:   state_reg <= S_T3;
        S_T3: begin
          opcode_reg <= ir_opcode;
          state_reg  <= legal_op ? S_T4 : S_ERR;
        end
        S_T4:   state_reg <= S_T5;
        S_T5:   state_reg <= is_ldi ? S_DONE : S_T6;
        S_T6: begin
          if (!is_ld || mem_ready) state_reg <= S_T7;
          else if (expired)        state_reg <= S_ERR;
        end
        S_T7: begin
          if (!is_st || mem_ready) state_reg <= S_DONE;
          else if (expired)        state_reg <= S_ERR;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Rin                 = 1'b0;
    Rout                = 1'b0;
    BAout               = 1'b0;
    alu_instruction     = '0;
    done                = 1'b0;
    mem_error           = 1'b0;
    case (state_reg)
      S_T0: begin
        PC_select           = 1'b1;
        MAR_enable          = 1'b1;
        PC_increment_enable = 1'b1;
        Z_enable            = 1'b1;
      end
      S_T1: begin
        Z_LO_select = 1'b1;
        PC_enable   = first_cycle;
        read        = 1'b1;
        MDR_enable  = mem_ready;
      end
      S_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        Grb      = 1'b1;
        BAout    = 1'b1;
        Y_enable = 1'b1;
      end
      S_T4: begin
        c_select        = 1'b1;
        alu_instruction = ALU_ADD;
        Z_enable        = 1'b1;
      end
      S_T5: begin
        Z_LO_select = 1'b1;
        if (is_ldi) begin
          Gra = 1'b1;
          Rin = 1'b1;
        end else begin
          MAR_enable = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          read       = 1'b1;
          MDR_enable = mem_ready;
        end else begin
          Gra        = 1'b1;
          Rout       = 1'b1;
          MDR_enable = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          Rin        = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      S_DONE: done      = 1'b1;
      S_ERR:  mem_error = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_reg != S_IDLE);
  assign state = state_reg;

endmodule

// File: tb/tb_mem_ctrl_sequencer.sv
// Directed bench for mem_ctrl_sequencer: a per-cycle vector table for a full
// load, then scenario runs for ldi, store waits, timeouts, bad opcode, reset.
module tb_mem_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [4:0] ir_opcode;
  logic PC_select, Z_LO_select, MDR_select, c_select;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic read, write, Gra, Grb, Rin, Rout, BAout;
  logic [4:0] alu_instruction;
  logic busy, done, mem_error;
  logic [3:0] state;

  always #5 clk = ~clk;

  mem_ctrl_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select), .c_select(c_select),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_instruction(alu_instruction), .busy(busy), .done(done), .mem_error(mem_error),
    .state(state)
  );

  localparam logic [20:0] C_PCSEL  = 21'd1 << 20;
  localparam logic [20:0] C_ZLO    = 21'd1 << 19;
  localparam logic [20:0] C_MDRSEL = 21'd1 << 18;
  localparam logic [20:0] C_CSEL   = 21'd1 << 17;
  localparam logic [20:0] C_PCEN   = 21'd1 << 16;
  localparam logic [20:0] C_PCINC  = 21'd1 << 15;
  localparam logic [20:0] C_IREN   = 21'd1 << 14;
  localparam logic [20:0] C_YEN    = 21'd1 << 13;
  localparam logic [20:0] C_ZEN    = 21'd1 << 12;
  localparam logic [20:0] C_MAREN  = 21'd1 << 11;
  localparam logic [20:0] C_MDREN  = 21'd1 << 10;
  localparam logic [20:0] C_RD     = 21'd1 << 9;
  localparam logic [20:0] C_WR     = 21'd1 << 8;
  localparam logic [20:0] C_GRA    = 21'd1 << 7;
  localparam logic [20:0] C_GRB    = 21'd1 << 6;
  localparam logic [20:0] C_RIN    = 21'd1 << 5;
  localparam logic [20:0] C_ROUT   = 21'd1 << 4;
  localparam logic [20:0] C_BA     = 21'd1 << 3;
  localparam logic [20:0] C_BUSY   = 21'd1 << 2;
  localparam logic [20:0] C_DONE   = 21'd1 << 1;
  localparam logic [20:0] C_ERR    = 21'd1;

  typedef struct packed {
    logic        start;
    logic        ready;
    logic [4:0]  opc;
    logic [3:0]  exp_state;
    logic [20:0] exp_ctrl;
    logic [4:0]  exp_alu;
  } vec_t;

  localparam int NVEC = 11;
  localparam int MAXC = 40;
  vec_t vec [NVEC];

  int checks = 0;
  int errors = 0;

  // per-run observations gathered by run_op
  int done_cyc, err_cyc, done_pulses, err_pulses, write_cnt, read_late;
  int rin_cnt, pcen_cnt, t1_cyc, t67_cnt, end_state;
  logic [20:0] t5_ctrl;

  function automatic logic [20:0] ctrl_word();
    return {PC_select, Z_LO_select, MDR_select, c_select, PC_enable, PC_increment_enable,
            IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, read, write,
            Gra, Grb, Rin, Rout, BAout, busy, done, mem_error};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Run one instruction for MAXC cycles; mem_ready is held low for the first
  // tN_low cycles spent in T1 / T6 / T7 respectively.
  task automatic run_op(input logic [4:0] opc, input int t1_low, input int t6_low, input int t7_low);
    logic [3:0] st, prev;
    int in_cnt;
    prev = 4'hF; in_cnt = 0;
    done_cyc = -1; err_cyc = -1; done_pulses = 0; err_pulses = 0; write_cnt = 0;
    read_late = 0; rin_cnt = 0; pcen_cnt = 0; t1_cyc = 0; t67_cnt = 0; t5_ctrl = '1;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      st = state;
      in_cnt = (st == prev) ? in_cnt + 1 : 0;
      prev = st;
      start = (c == 0);
      ir_opcode = opc;
      mem_ready = !((st == 4'd2 && in_cnt < t1_low) ||
                    (st == 4'd7 && in_cnt < t6_low) ||
                    (st == 4'd8 && in_cnt < t7_low));
      #1;
      if (done) begin done_pulses++; if (done_cyc < 0) done_cyc = c; end
      if (mem_error) begin err_pulses++; if (err_cyc < 0) err_cyc = c; end
      if (write) write_cnt++;
      if (read && st != 4'd2) read_late++;
      if (Rin) rin_cnt++;
      if (PC_enable) pcen_cnt++;
      if (st == 4'd2) t1_cyc++;
      if (st == 4'd6) t5_ctrl = ctrl_word();
      if (st == 4'd7 || st == 4'd8) t67_cnt++;
    end
    end_state = int'(state);
  endtask

  initial begin
    // Full ld with mem_ready high; a stray start in T4 must be ignored.
    vec[0]  = '{1'b1, 1'b1, 5'd0, 4'd0,  21'd0, 5'd0};
    vec[1]  = '{1'b0, 1'b1, 5'd0, 4'd1,  C_PCSEL | C_MAREN | C_PCINC | C_ZEN | C_BUSY, 5'd0};
    vec[2]  = '{1'b0, 1'b1, 5'd0, 4'd2,  C_ZLO | C_PCEN | C_RD | C_MDREN | C_BUSY, 5'd0};
    vec[3]  = '{1'b0, 1'b1, 5'd0, 4'd3,  C_MDRSEL | C_IREN | C_BUSY, 5'd0};
    vec[4]  = '{1'b0, 1'b1, 5'd0, 4'd4,  C_GRB | C_BA | C_YEN | C_BUSY, 5'd0};
    vec[5]  = '{1'b1, 1'b1, 5'd0, 4'd5,  C_CSEL | C_ZEN | C_BUSY, 5'd3};
    vec[6]  = '{1'b0, 1'b1, 5'd0, 4'd6,  C_ZLO | C_MAREN | C_BUSY, 5'd0};
    vec[7]  = '{1'b0, 1'b1, 5'd0, 4'd7,  C_RD | C_MDREN | C_BUSY, 5'd0};
    vec[8]  = '{1'b0, 1'b1, 5'd0, 4'd8,  C_MDRSEL | C_GRA | C_RIN | C_BUSY, 5'd0};
    vec[9]  = '{1'b0, 1'b1, 5'd0, 4'd9,  C_DONE | C_BUSY, 5'd0};
    vec[10] = '{1'b0, 1'b1, 5'd0, 4'd0,  21'd0, 5'd0};

    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_opcode = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      start = vec[i].start;
      mem_ready = vec[i].ready;
      ir_opcode = vec[i].opc;
      #1;
      chk($sformatf("ld cyc%0d state", i), int'(state), int'(vec[i].exp_state));
      chk($sformatf("ld cyc%0d ctrl", i), int'(ctrl_word()), int'(vec[i].exp_ctrl));
      chk($sformatf("ld cyc%0d alu", i), int'(alu_instruction), int'(vec[i].exp_alu));
    end

    run_op(5'b00001, 0, 0, 0);
    chk("ldi done cycle", done_cyc, 7);
    chk("ldi done pulses", done_pulses, 1);
    chk("ldi T5 ctrl", int'(t5_ctrl), int'(C_ZLO | C_GRA | C_RIN | C_BUSY));
    chk("ldi T6/T7 cycles", t67_cnt, 0);

    run_op(5'b00010, 0, 0, 3);
    chk("st done cycle", done_cyc, 12);
    chk("st write cycles", write_cnt, 4);
    chk("st late read", read_late, 0);
    chk("st done pulses", done_pulses, 1);

    run_op(5'b00000, 100, 0, 0);
    chk("fetch timeout T1 cycles", t1_cyc, 15);
    chk("fetch timeout err cycle", err_cyc, 17);
    chk("fetch timeout err pulses", err_pulses, 1);
    chk("fetch timeout done pulses", done_pulses, 0);
    chk("fetch timeout end state", end_state, 0);

    run_op(5'b11111, 0, 0, 0);
    chk("bad opcode err cycle", err_cyc, 5);
    chk("bad opcode err pulses", err_pulses, 1);
    chk("bad opcode Rin", rin_cnt, 0);
    chk("bad opcode write", write_cnt, 0);
    chk("bad opcode done", done_pulses, 0);

    run_op(5'b00000, 2, 1, 0);
    chk("ld waits done cycle", done_cyc, 12);
    chk("ld waits PC_enable cycles", pcen_cnt, 1);

    run_op(5'b00000, 0, 14, 0);
    chk("ld ready-on-last done cycle", done_cyc, 23);
    chk("ld ready-on-last err pulses", err_pulses, 0);

    // Reset while an ld sits in T6.
    begin
      int guard, dcnt;
      guard = 0; dcnt = 0;
      @(negedge clk);
      start = 1'b1; mem_ready = 1'b0; ir_opcode = 5'd0;
      while (state != 4'd7 && guard < 30) begin
        @(negedge clk);
        start = 1'b0;
        mem_ready = (state == 4'd2);
        guard++;
      end
      chk("reach ld T6 before reset", int'(state), 7);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("reset mid-op state", int'(state), 0);
      chk("reset mid-op ctrl", int'(ctrl_word()), 0);
      reset = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        if (done || mem_error) dcnt++;
      end
      chk("reset mid-op no done/error", dcnt, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
